fir_tap_loader: RTL and testbench

Host-side writer for the FIR dynamic-tap load port: it holds a shadow coefficient bank that software fills at any address order, then on command streams the full set into a `fastfir`-style filter's `i_tap_wr`/`i_tap` shift-in port, one tap per clock.
It sits between the register interface and the filter instance, so taps are always replaced as a complete, coherent set and never half-written.

---
 rtl/fir_tap_loader_pkg.sv | 20 ++
 rtl/fir_tap_loader_bank.sv | 43 ++++
 rtl/fir_tap_loader.sv | 145 ++++++++++++++
 tb/tb_fir_tap_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_tap_loader_pkg.sv
// Shared types and width helpers for the FIR tap loader.
// Optional checksum support is enabled with FIR_TAPLOAD_CHECKSUM_EN.
package fir_tap_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } load_state_t;

    function automatic int tap_addr_w(input int ntaps);
        return (ntaps > 1) ? $clog2(ntaps) : 1;
    endfunction

    function automatic int cksum_w(input int tw, input int lgntaps);
        return tw + lgntaps;
    endfunction

endpackage

// File: rtl/fir_tap_loader_bank.sv
// Shadow coefficient bank: one write port, one registered read port.
// Storage is not reset; only the read register clears, so idle reads present zero.
module fir_tap_bank
    import fir_tap_loader_pkg::*;
#(
    parameter int NTAPS   = 16,
    parameter int TW      = 12,
    parameter int LGNTAPS = tap_addr_w(NTAPS)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_we,
    input  logic [LGNTAPS-1:0] i_waddr,
    input  logic [TW-1:0]      i_wdata,
    input  logic               i_re,
    input  logic [LGNTAPS-1:0] i_raddr,
    output logic [TW-1:0]      o_rdata
);

    logic [TW-1:0] mem_r [NTAPS];
    logic [TW-1:0] rdata_r;

    // Coefficient storage write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_r[i_waddr] <= i_wdata;
        end
    end

    // Registered read; zero whenever no read is requested
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rdata_r <= {TW{1'b0}};
        end else if (i_re) begin
            rdata_r <= mem_r[i_raddr];
        end else begin
            rdata_r <= {TW{1'b0}};
        end
    end

    assign o_rdata = rdata_r;

endmodule

// File: rtl/fir_tap_loader.sv
// Streams a complete shadow tap bank into a fastfir-style tap shift-in port.
// Define FIR_TAPLOAD_CHECKSUM_EN to add the o_checksum port and accumulator.
module fir_tap_loader
    import fir_tap_loader_pkg::*;
#(
    parameter int NTAPS   = 16,
    parameter int TW      = 12,
    parameter int LGNTAPS = tap_addr_w(NTAPS)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr,
    input  logic [LGNTAPS-1:0] i_waddr,
    input  logic [TW-1:0]      i_wdata,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_tap_wr,
    output logic [TW-1:0]      o_tap
`ifdef FIR_TAPLOAD_CHECKSUM_EN
    ,
    output logic [cksum_w(TW, LGNTAPS)-1:0] o_checksum
`endif
);

    load_state_t        state_r;
    logic [LGNTAPS-1:0] raddr_r;
    logic               last_r;
    logic               busy_r;
    logic               done_r;
    logic               tap_wr_r;
    logic               we_s;
    logic               re_s;

    // Bank access gating: writes only in IDLE, reads while priming or streaming
    always_comb begin
        we_s = 1'b0;
        re_s = 1'b0;
        if (state_r == ST_IDLE) begin
            we_s = i_wr;
        end else if (state_r == ST_PRIME) begin
            re_s = 1'b1;
        end else if (state_r == ST_STREAM) begin
            re_s = ~last_r;
        end else begin
            re_s = 1'b0;
        end
    end

    fir_tap_bank #(
        .NTAPS   (NTAPS),
        .TW      (TW),
        .LGNTAPS (LGNTAPS)
    ) u_bank (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (we_s),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .i_re    (re_s),
        .i_raddr (raddr_r),
        .o_rdata (o_tap)
    );

    // Load sequencer; last_r marks that address 0 has been read and is on o_tap
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            raddr_r  <= {LGNTAPS{1'b0}};
            last_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            tap_wr_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r   <= 1'b0;
                    tap_wr_r <= 1'b0;
                    last_r   <= 1'b0;
                    if (i_start) begin
                        state_r <= ST_PRIME;
                        raddr_r <= LGNTAPS'(NTAPS - 1);
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_PRIME, ST_STREAM: begin
                    if (last_r) begin
                        state_r  <= ST_DONE;
                        tap_wr_r <= 1'b0;
                        done_r   <= 1'b1;
                        last_r   <= 1'b0;
                    end else begin
                        state_r  <= ST_STREAM;
                        tap_wr_r <= 1'b1;
                        if (raddr_r == {LGNTAPS{1'b0}}) begin
                            last_r <= 1'b1;
                        end else begin
                            raddr_r <= raddr_r - LGNTAPS'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    raddr_r  <= {LGNTAPS{1'b0}};
                    last_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    tap_wr_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = busy_r;
    assign o_done   = done_r;
    assign o_tap_wr = tap_wr_r;

`ifdef FIR_TAPLOAD_CHECKSUM_EN
    localparam int CKW = cksum_w(TW, LGNTAPS);
    logic [CKW-1:0] cksum_r;

    // Sum of every presented tap, sign-extended; cleared when a stream is accepted
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cksum_r <= {CKW{1'b0}};
        end else if ((state_r == ST_IDLE) && i_start) begin
            cksum_r <= {CKW{1'b0}};
        end else if (state_r == ST_STREAM) begin
            cksum_r <= cksum_r + {{LGNTAPS{o_tap[TW-1]}}, o_tap};
        end else begin
            cksum_r <= cksum_r;
        end
    end

    assign o_checksum = cksum_r;
`endif

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed self-checking bench for fir_tap_loader (NTAPS=16, TW=12).
// Checksum comparisons are compiled only when FIR_TAPLOAD_CHECKSUM_EN is defined.
module tb_fir_tap_loader;

    localparam int NTAPS = 16;
    localparam int TW    = 12;
    localparam int LG    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_wr;
    logic [LG-1:0] i_waddr;
    logic [TW-1:0] i_wdata;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic          o_tap_wr;
    logic [TW-1:0] o_tap;
`ifdef FIR_TAPLOAD_CHECKSUM_EN
    logic [TW+LG-1:0] o_checksum;
`endif

    int total = 0;
    int bad   = 0;

    logic [TW-1:0] cap_q[$];
    int done_cnt, first_wr, last_wr, done_cyc, busy_off;

    always #5 clk = ~clk;

    fir_tap_loader #(.NTAPS(NTAPS), .TW(TW), .LGNTAPS(LG)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_wr     (i_wr),
        .i_waddr  (i_waddr),
        .i_wdata  (i_wdata),
        .i_start  (i_start),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_tap_wr (o_tap_wr),
        .o_tap    (o_tap)
`ifdef FIR_TAPLOAD_CHECKSUM_EN
        ,
        .o_checksum (o_checksum)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bank(input logic [LG-1:0] a, input logic [TW-1:0] d);
        i_wr = 1'b1; i_waddr = a; i_wdata = d;
        tick();
        i_wr = 1'b0;
    endtask

    // Pulse start (optionally with a write), then observe 40 cycles; cycle c is after edge c-1.
    // mid_kind: 0 none, 1 start during cycle mid_cyc, 2 write during cycle mid_cyc
    task automatic run_stream(input bit with_wr, input logic [LG-1:0] wa, input logic [TW-1:0] wd,
                              input int mid_kind, input int mid_cyc,
                              input logic [LG-1:0] ma, input logic [TW-1:0] md);
        cap_q.delete();
        done_cnt = 0; first_wr = -1; last_wr = -1; done_cyc = -1; busy_off = -1;
        i_start = 1'b1;
        if (with_wr) begin
            i_wr = 1'b1; i_waddr = wa; i_wdata = wd;
        end
        tick();
        i_start = 1'b0; i_wr = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            i_start = (mid_kind == 1 && c == mid_cyc);
            i_wr    = (mid_kind == 2 && c == mid_cyc);
            if (mid_kind == 2) begin
                i_waddr = ma; i_wdata = md;
            end
            if (o_tap_wr) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                cap_q.push_back(o_tap);
            end
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!o_busy && busy_off < 0) busy_off = c;
            tick();
        end
        i_start = 1'b0; i_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_wr = 1'b0; i_waddr = '0; i_wdata = '0; i_start = 1'b0;
        tick(); tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
        total++; if (o_tap_wr !== 1'b0) begin bad++; $display("FAIL reset_tap_wr got=%b exp=0", o_tap_wr); end
        total++; if (o_tap !== 12'h000) begin bad++; $display("FAIL reset_tap got=%h exp=000", o_tap); end
`ifdef FIR_TAPLOAD_CHECKSUM_EN
        total++; if (o_checksum !== 16'h0000) begin bad++; $display("FAIL reset_checksum got=%h exp=0000", o_checksum); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        for (int k = 0; k < NTAPS; k++) write_bank(LG'(k), TW'(k + 1));
        run_stream(1'b0, '0, '0, 0, 0, '0, '0);
        total++; if (cap_q.size() !== 16) begin bad++; $display("FAIL full_count got=%0d exp=16", cap_q.size()); end
        total++; if (first_wr !== 2) begin bad++; $display("FAIL full_first_wr got=%0d exp=2", first_wr); end
        total++; if (last_wr !== 17) begin bad++; $display("FAIL full_last_wr got=%0d exp=17", last_wr); end
        for (int i = 0; i < cap_q.size(); i++) begin
            total++;
            if (cap_q[i] !== TW'(16 - i)) begin bad++; $display("FAIL full_tap[%0d] got=%h exp=%h", i, cap_q[i], TW'(16 - i)); end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); end
        total++; if (done_cyc !== 18) begin bad++; $display("FAIL full_done_cyc got=%0d exp=18", done_cyc); end
        total++; if (busy_off !== 19) begin bad++; $display("FAIL full_busy_off got=%0d exp=19", busy_off); end
`ifdef FIR_TAPLOAD_CHECKSUM_EN
        total++; if (o_checksum !== 16'd136) begin bad++; $display("FAIL full_checksum got=%0d exp=136", o_checksum); end
`endif
    endtask

    task automatic test_signed();
        for (int k = 0; k < NTAPS; k++) write_bank(LG'(k), 12'hFFF);
        run_stream(1'b0, '0, '0, 0, 0, '0, '0);
        total++; if (cap_q.size() !== 16) begin bad++; $display("FAIL signed_count got=%0d exp=16", cap_q.size()); end
        total++; if (cap_q[0] !== 12'hFFF) begin bad++; $display("FAIL signed_tap0 got=%h exp=fff", cap_q[0]); end
`ifdef FIR_TAPLOAD_CHECKSUM_EN
        total++; if (o_checksum !== 16'hFFF0) begin bad++; $display("FAIL signed_checksum got=%h exp=fff0", o_checksum); end
`endif
    endtask

    task automatic test_frozen_bank();
        for (int k = 0; k < NTAPS; k++) write_bank(LG'(k), TW'(k + 1));
        run_stream(1'b0, '0, '0, 2, 6, 4'd0, 12'h7FF);
        total++; if (cap_q[15] !== 12'h001) begin bad++; $display("FAIL frozen_last got=%h exp=001", cap_q[15]); end
        total++; if (cap_q[10] !== 12'h006) begin bad++; $display("FAIL frozen_mid got=%h exp=006", cap_q[10]); end
        write_bank(4'd0, 12'h7FF);
        run_stream(1'b0, '0, '0, 0, 0, '0, '0);
        total++; if (cap_q[15] !== 12'h7FF) begin bad++; $display("FAIL frozen_second_last got=%h exp=7ff", cap_q[15]); end
    endtask

    task automatic test_start_collision();
        run_stream(1'b0, '0, '0, 1, 5, '0, '0);
        total++; if (cap_q.size() !== 16) begin bad++; $display("FAIL restart5_count got=%0d exp=16", cap_q.size()); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL restart5_done_cnt got=%0d exp=1", done_cnt); end
        run_stream(1'b1, 4'd15, 12'h123, 0, 0, '0, '0);
        total++; if (cap_q[0] !== 12'h123) begin bad++; $display("FAIL wr_start_first got=%h exp=123", cap_q[0]); end
        total++; if (cap_q[1] !== 12'h00F) begin bad++; $display("FAIL wr_start_second got=%h exp=00f", cap_q[1]); end
    endtask

    task automatic test_back_to_back();
        run_stream(1'b0, '0, '0, 1, 18, '0, '0);
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL b2b_early_done_cnt got=%0d exp=1", done_cnt); end
        run_stream(1'b0, '0, '0, 1, 19, '0, '0);
        total++; if (cap_q.size() !== 32) begin bad++; $display("FAIL b2b_count got=%0d exp=32", cap_q.size()); end
        total++; if (done_cnt !== 2) begin bad++; $display("FAIL b2b_done_cnt got=%0d exp=2", done_cnt); end
        total++; if (last_wr !== 36) begin bad++; $display("FAIL b2b_last_wr got=%0d exp=36", last_wr); end
        total++; if (cap_q[16] !== 12'h123) begin bad++; $display("FAIL b2b_second_first got=%h exp=123", cap_q[16]); end
    endtask

    task automatic test_reset_mid_stream();
        int dn;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        total++; if (o_tap_wr !== 1'b1) begin bad++; $display("FAIL midrst_pre_tap_wr got=%b exp=1", o_tap_wr); end
        rst = 1'b1;
        #1;
        total++; if (o_tap_wr !== 1'b0) begin bad++; $display("FAIL midrst_tap_wr got=%b exp=0", o_tap_wr); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
        total++; if (o_tap !== 12'h000) begin bad++; $display("FAIL midrst_tap got=%h exp=000", o_tap); end
        tick();
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_done || o_tap_wr) dn++;
            tick();
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", dn); end
        run_stream(1'b0, '0, '0, 0, 0, '0, '0);
        total++; if (cap_q.size() !== 16) begin bad++; $display("FAIL midrst_restart_count got=%0d exp=16", cap_q.size()); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL midrst_restart_done got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_signed();
        test_frozen_bank();
        test_start_collision();
        test_back_to_back();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
